// File: rtl/diffeq_pkg.sv
// Shared types and default widths for the diffeq solver job controller.
package diffeq_pkg;

  localparam int unsigned DIFFEQ_WIDTH  = 32;
  localparam int unsigned DIFFEQ_ITER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/diffeq_iter_counter.sv
// Saturating iteration counter: clears on job accept, counts solver updates.
module diffeq_iter_counter #(
  parameter int unsigned ITER_W    = 16,
  parameter int unsigned MAX_COUNT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ITER_W-1:0] count,
  output logic              at_max
);

  localparam logic [ITER_W-1:0] MAX_V = ITER_W'(MAX_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/diffeq_job_ctrl.sv
// Runs one solver job per request: holds the solver in reset when idle,
// detects x >= a or iteration timeout, and returns the final solver state.
module diffeq_job_ctrl
  import diffeq_pkg::*;
#(
  parameter int unsigned WIDTH    = DIFFEQ_WIDTH,
  parameter int unsigned ITER_W   = DIFFEQ_ITER_W,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_dx,
  output logic              sol_reset,
  output logic [WIDTH-1:0]  sol_a,
  output logic [WIDTH-1:0]  sol_dx,
  input  logic [WIDTH-1:0]  sol_x,
  input  logic [WIDTH-1:0]  sol_y,
  input  logic [WIDTH-1:0]  sol_u,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_x,
  output logic [WIDTH-1:0]  rsp_y,
  output logic [WIDTH-1:0]  rsp_u,
  output logic [ITER_W-1:0] rsp_iters,
  output logic              rsp_timeout,
  output logic              busy
);

  state_e            state;
  state_e            state_nxt;
  logic              accept;
  logic              done_hit;
  logic              tmo_hit;
  logic              cnt_en;
  logic [ITER_W-1:0] iters;
  logic              at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Completion wins over timeout when both hold in the same cycle.
        if (sol_x >= sol_a) begin
          done_hit  = 1'b1;
          state_nxt = ST_RSP;
        end else if (at_max) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_RSP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags decode the state register only, never the other side's valid/ready.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RSP);
  assign busy      = (state != ST_IDLE);
  assign sol_reset = reset | (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      sol_a       <= '0;
      sol_dx      <= '0;
      rsp_x       <= '0;
      rsp_y       <= '0;
      rsp_u       <= '0;
      rsp_iters   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        sol_a  <= req_a;
        sol_dx <= req_dx;
      end
      if (done_hit || tmo_hit) begin
        rsp_x       <= sol_x;
        rsp_y       <= sol_y;
        rsp_u       <= sol_u;
        rsp_iters   <= iters;
        rsp_timeout <= tmo_hit;
      end
    end
  end

  diffeq_iter_counter #(
    .ITER_W    (ITER_W),
    .MAX_COUNT (MAX_ITER)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (cnt_en),
    .count  (iters),
    .at_max (at_max)
  );

endmodule
